// File: rtl/circuit1_accum_if.sv
// Handshake and result bus between the circuit1 datapath and its batch accumulator.
// master (producer/controller side): drives i_start, i_in_valid, i_z and i_x;
//                                    observes o_in_ready, o_busy, o_done, o_sum_x, o_max_z and o_count.
// slave  (accumulator side):         the reverse directions.
interface circuit1_accum_if;
    localparam int unsigned Z_W   = 8;
    localparam int unsigned X_W   = 16;
    localparam int unsigned SUM_W = 24;
    localparam int unsigned CNT_W = 8;

    logic             i_start;
    logic             i_in_valid;
    logic [Z_W-1:0]   i_z;
    logic [X_W-1:0]   i_x;
    logic             o_in_ready;
    logic             o_busy;
    logic             o_done;
    logic [SUM_W-1:0] o_sum_x;
    logic [Z_W-1:0]   o_max_z;
    logic [CNT_W-1:0] o_count;

    modport master (
        output i_start, i_in_valid, i_z, i_x,
        input  o_in_ready, o_busy, o_done, o_sum_x, o_max_z, o_count
    );

    modport slave (
        input  i_start, i_in_valid, i_z, i_x,
        output o_in_ready, o_busy, o_done, o_sum_x, o_max_z, o_count
    );
endinterface

// File: rtl/circuit1_accum.sv
// Batch accumulator for circuit1 results: after a Start it accepts N_SAMPLES
// (z, x) pairs, summing x and tracking the maximum z, then pulses Done once.
// Ports:
//   i_clk   - rising-edge clock
//   i_rst_n - asynchronous active-low reset
//   bus     - circuit1_accum_if.slave: start / valid / z / x in,
//             in_ready / busy / done / sum_x / max_z / count out
// N_SAMPLES must lie in 1..255, which also keeps the 24-bit sum from wrapping.
module circuit1_accum #(
    parameter int unsigned N_SAMPLES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    circuit1_accum_if.slave  bus
);
    localparam int unsigned SUM_W = 24;
    localparam int unsigned Z_W   = 8;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_in_ready;
    logic               w_busy;
    logic               w_done;
    logic               w_accept;
    logic               w_clear;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_done;
    logic [SUM_W-1:0]   r_sum_x;
    logic [Z_W-1:0]     r_max_z;
    logic [CNT_W-1:0]   r_count;

    // State register; the status outputs are registered copies of the next-state decode,
    // so they always match the current state without any path from the inputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= w_in_ready;
            r_busy     <= w_busy;
            r_done     <= w_done;
        end
    end

    // Next-state and status decode.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_clear    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_clear = 1'b1;
                    w_next  = S_ACCUM;
                end
            end
            S_ACCUM: begin
                w_accept = bus.i_in_valid;
                if (bus.i_in_valid && (r_count == LAST_CNT)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        w_in_ready = (w_next == S_ACCUM);
        w_busy     = (w_next != S_IDLE);
        w_done     = (w_next == S_DONE);
    end

    // Result registers: cleared when a batch starts, updated only on an accept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum_x <= '0;
            r_max_z <= '0;
            r_count <= '0;
        end else if (w_clear) begin
            r_sum_x <= '0;
            r_max_z <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_sum_x <= r_sum_x + SUM_W'(bus.i_x);
            r_max_z <= (bus.i_z > r_max_z) ? bus.i_z : r_max_z;
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign bus.o_in_ready = r_in_ready;
    assign bus.o_busy     = r_busy;
    assign bus.o_done     = r_done;
    assign bus.o_sum_x    = r_sum_x;
    assign bus.o_max_z    = r_max_z;
    assign bus.o_count    = r_count;
endmodule
